// File: rtl/buraq_wb_pkg.sv
// Shared types for the BURAQ MEM/WB writeback stage: result-source select, load funct3 codes and pipeline register layout.
// Used by writeback_stage and load_extend.
package buraq_wb_pkg;

  localparam int WB_XLEN   = 32;
  localparam int WB_REG_AW = 5;

  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_MEM = 2'd1,
    WB_PC4 = 2'd2,
    WB_CSR = 2'd3
  } wb_sel_e;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;

  // we already folds in reg_we, rd != 0 and the misalign drop
  typedef struct packed {
    logic                 valid;
    logic                 we;
    logic                 misalign;
    logic [WB_REG_AW-1:0] rd;
    logic [WB_XLEN-1:0]   data;
  } wb_stage_t;

endpackage

// File: rtl/load_extend.sv
// Combinational load alignment and sign/zero extension for the writeback stage.
// Reserved funct3 codes decode as LW.
module load_extend
  import buraq_wb_pkg::*;
#(
  parameter int DATA_WIDTH = WB_XLEN
) (
  input  logic [2:0]            funct3,
  input  logic [1:0]            off,
  input  logic [DATA_WIDTH-1:0] word,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  misalign
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (off)
      2'd0:    byte_sel = word[7:0];
      2'd1:    byte_sel = word[15:8];
      2'd2:    byte_sel = word[23:16];
      default: byte_sel = word[31:24];
    endcase
    half_sel = off[1] ? word[31:16] : word[15:0];
  end

  always_comb begin
    data     = word;
    misalign = 1'b0;
    case (funct3)
      LB:  data = {{(DATA_WIDTH-8){byte_sel[7]}}, byte_sel};
      LBU: data = {{(DATA_WIDTH-8){1'b0}}, byte_sel};
      LH: begin
        data     = {{(DATA_WIDTH-16){half_sel[15]}}, half_sel};
        misalign = off[0];
      end
      LHU: begin
        data     = {{(DATA_WIDTH-16){1'b0}}, half_sel};
        misalign = off[0];
      end
      LW: begin
        data     = word;
        misalign = |off;
      end
      default: begin
        data     = word;
        misalign = |off;
      end
    endcase
  end

endmodule

// File: rtl/writeback_stage.sv
// Registered MEM/WB writeback stage: source mux, load extension, one RF write per retired instruction, forwarding bus.
// Optional retire counter enabled by defining WB_RETIRE_CNT_EN.
module writeback_stage
  import buraq_wb_pkg::*;
#(
  parameter int DATA_WIDTH     = WB_XLEN,
  parameter int REG_ADDR_WIDTH = WB_REG_AW
`ifdef WB_RETIRE_CNT_EN
  , parameter int CNT_WIDTH    = 64
`endif
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      stall,
  input  logic                      flush,
  input  logic                      in_reg_we,
  input  logic [REG_ADDR_WIDTH-1:0] in_rd,
  input  logic [1:0]                in_wb_sel,
  input  logic [2:0]                in_ld_funct3,
  input  logic [1:0]                in_addr_lo,
  input  logic [DATA_WIDTH-1:0]     in_alu_data,
  input  logic [DATA_WIDTH-1:0]     in_mem_data,
  input  logic [DATA_WIDTH-1:0]     in_pc4,
  input  logic [DATA_WIDTH-1:0]     in_csr_data,
  output logic                      rf_we,
  output logic [REG_ADDR_WIDTH-1:0] rf_waddr,
  output logic [DATA_WIDTH-1:0]     rf_wdata,
  output logic                      fwd_valid,
  output logic [REG_ADDR_WIDTH-1:0] fwd_rd,
  output logic [DATA_WIDTH-1:0]     fwd_data,
  output logic                      ld_misalign
`ifdef WB_RETIRE_CNT_EN
  , output logic [CNT_WIDTH-1:0]    retire_count
`endif
);

  logic                  accept;
  logic                  is_mem;
  logic                  ld_mis;
  logic                  drop;
  logic [DATA_WIDTH-1:0] ld_data;
  logic [DATA_WIDTH-1:0] src_data;
  wb_stage_t             wb_q;

  assign in_ready = ~stall;
  assign accept   = in_valid & ~stall & ~flush;

  load_extend #(.DATA_WIDTH(DATA_WIDTH)) u_load_extend (
    .funct3   (in_ld_funct3),
    .off      (in_addr_lo),
    .word     (in_mem_data),
    .data     (ld_data),
    .misalign (ld_mis)
  );

  assign is_mem = (wb_sel_e'(in_wb_sel) == WB_MEM);
  assign drop   = is_mem & ld_mis;

  always_comb begin
    src_data = in_alu_data;
    case (wb_sel_e'(in_wb_sel))
      WB_MEM:  src_data = ld_data;
      WB_PC4:  src_data = in_pc4;
      WB_CSR:  src_data = in_csr_data;
      default: src_data = in_alu_data;
    endcase
  end

  // valid is rewritten every cycle so a stall can never replay a write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_q <= '0;
    end else begin
      wb_q.valid    <= accept;
      wb_q.misalign <= accept & drop;
      if (accept) begin
        wb_q.we   <= in_reg_we & (in_rd != '0) & ~drop;
        wb_q.rd   <= in_rd;
        wb_q.data <= src_data;
      end
    end
  end

  assign rf_we       = wb_q.valid & wb_q.we;
  assign rf_waddr    = wb_q.rd;
  assign rf_wdata    = wb_q.data;
  assign fwd_valid   = rf_we;
  assign fwd_rd      = wb_q.rd;
  assign fwd_data    = wb_q.data;
  assign ld_misalign = wb_q.misalign;

`ifdef WB_RETIRE_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retire_count <= '0;
    end else if (wb_q.valid & ~wb_q.misalign) begin
      retire_count <= retire_count + CNT_WIDTH'(1);
    end
  end
`endif

endmodule

// File: tb/tb_writeback_stage.sv
// Self-checking bench for writeback_stage: directed steps plus randomized traffic against an arithmetic reference model.
// Define WB_RETIRE_CNT_EN to also exercise the retire counter (instantiated narrow so wrap is reachable).
module tb_writeback_stage;

  localparam int TB_CNT_W = 4;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        stall;
  logic        flush;
  logic        in_reg_we;
  logic [4:0]  in_rd;
  logic [1:0]  in_wb_sel;
  logic [2:0]  in_ld_funct3;
  logic [1:0]  in_addr_lo;
  logic [31:0] in_alu_data;
  logic [31:0] in_mem_data;
  logic [31:0] in_pc4;
  logic [31:0] in_csr_data;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        fwd_valid;
  logic [4:0]  fwd_rd;
  logic [31:0] fwd_data;
  logic        ld_misalign;
`ifdef WB_RETIRE_CNT_EN
  logic [TB_CNT_W-1:0] retire_count;
  logic [TB_CNT_W-1:0] exp_cnt;
`endif

  int tests_run;
  int tests_failed;

  writeback_stage #(
    .DATA_WIDTH     (32),
    .REG_ADDR_WIDTH (5)
`ifdef WB_RETIRE_CNT_EN
    , .CNT_WIDTH    (TB_CNT_W)
`endif
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .stall        (stall),
    .flush        (flush),
    .in_reg_we    (in_reg_we),
    .in_rd        (in_rd),
    .in_wb_sel    (in_wb_sel),
    .in_ld_funct3 (in_ld_funct3),
    .in_addr_lo   (in_addr_lo),
    .in_alu_data  (in_alu_data),
    .in_mem_data  (in_mem_data),
    .in_pc4       (in_pc4),
    .in_csr_data  (in_csr_data),
    .rf_we        (rf_we),
    .rf_waddr     (rf_waddr),
    .rf_wdata     (rf_wdata),
    .fwd_valid    (fwd_valid),
    .fwd_rd       (fwd_rd),
    .fwd_data     (fwd_data),
    .ld_misalign  (ld_misalign)
`ifdef WB_RETIRE_CNT_EN
    , .retire_count (retire_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: pick the source, then slice the memory word arithmetically
  function automatic void ref_model(input logic [1:0] sel, input logic [2:0] f3, input logic [1:0] off,
                                    input logic [31:0] alu, input logic [31:0] mem,
                                    input logic [31:0] pc4, input logic [31:0] csr,
                                    output logic [31:0] d, output logic mis);
    int unsigned b;
    int unsigned h;
    int unsigned o;
    o   = int'(off);
    b   = (mem >> (8 * o)) & 32'hFF;
    h   = (mem >> (16 * (o / 2))) & 32'hFFFF;
    mis = 1'b0;
    d   = alu;
    case (sel)
      2'd0: d = alu;
      2'd2: d = pc4;
      2'd3: d = csr;
      default: begin
        case (f3)
          3'd0: d = (b >= 128) ? b - 256 : b;
          3'd4: d = b;
          3'd1: begin d = (h >= 32768) ? h - 65536 : h; mis = (o % 2) != 0; end
          3'd5: begin d = h; mis = (o % 2) != 0; end
          default: begin d = mem; mis = (o != 0); end
        endcase
      end
    endcase
  endfunction

  // Called at a negedge: drive one cycle of inputs, then check the registered result at the next negedge.
  task automatic cycle(input logic v, input logic s, input logic f, input logic we, input logic [4:0] rd,
                       input logic [1:0] sel, input logic [2:0] f3, input logic [1:0] off,
                       input logic [31:0] alu, input logic [31:0] mem,
                       input logic [31:0] pc4, input logic [31:0] csr);
    logic        acc;
    logic [31:0] d;
    logic        mis;
    logic        e_we;
    logic        e_mis;
    in_valid = v; stall = s; flush = f; in_reg_we = we; in_rd = rd;
    in_wb_sel = sel; in_ld_funct3 = f3; in_addr_lo = off;
    in_alu_data = alu; in_mem_data = mem; in_pc4 = pc4; in_csr_data = csr;
    #1;
    chk("in_ready", in_ready, !s);
    ref_model(sel, f3, off, alu, mem, pc4, csr, d, mis);
    acc   = v && !s && !f;
    e_mis = acc && mis;
    e_we  = acc && we && (rd != 0) && !mis;
    @(negedge clk);
    chk("rf_we", rf_we, e_we);
    chk("fwd_valid", fwd_valid, e_we);
    chk("ld_misalign", ld_misalign, e_mis);
    if (e_we) begin
      chk("rf_waddr", rf_waddr, rd);
      chk("rf_wdata", rf_wdata, d);
      chk("fwd_rd", fwd_rd, rd);
      chk("fwd_data", fwd_data, d);
    end
`ifdef WB_RETIRE_CNT_EN
    chk("retire_count", retire_count, exp_cnt);
    if (acc && !mis) exp_cnt = exp_cnt + 1'b1;
`endif
  endtask

  task automatic idle();
    cycle(0, 0, 0, 0, 5'd0, 2'd0, 3'd0, 2'd0, 32'h0, 32'h0, 32'h0, 32'h0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rf_we"}, rf_we, 0);
    chk({tag, "_rf_waddr"}, rf_waddr, 0);
    chk({tag, "_rf_wdata"}, rf_wdata, 0);
    chk({tag, "_fwd_valid"}, fwd_valid, 0);
    chk({tag, "_fwd_rd"}, fwd_rd, 0);
    chk({tag, "_fwd_data"}, fwd_data, 0);
    chk({tag, "_ld_misalign"}, ld_misalign, 0);
`ifdef WB_RETIRE_CNT_EN
    chk({tag, "_retire_count"}, retire_count, 0);
`endif
  endtask

  localparam logic [31:0] MEMW = 32'h8070F0A5;

  initial begin
    tests_run = 0;
    tests_failed = 0;
    rst_n = 1'b0;
    in_valid = 0; stall = 0; flush = 0; in_reg_we = 0; in_rd = 0;
    in_wb_sel = 0; in_ld_funct3 = 0; in_addr_lo = 0;
    in_alu_data = 0; in_mem_data = 0; in_pc4 = 0; in_csr_data = 0;
`ifdef WB_RETIRE_CNT_EN
    exp_cnt = '0;
`endif
    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;

    // ALU write, then a bubble
    cycle(1, 0, 0, 1, 5'd5, 2'd0, 3'd0, 2'd0, 32'hDEADBEEF, 32'h0, 32'h0, 32'h0);
    chk("alu_wdata_const", rf_wdata, 32'hDEADBEEF);
    idle();

    // Loads from one memory word
    cycle(1, 0, 0, 1, 5'd7, 2'd1, 3'b000, 2'd0, 32'h1, MEMW, 32'h0, 32'h0);
    chk("lb_const", rf_wdata, 32'hFFFFFFA5);
    cycle(1, 0, 0, 1, 5'd7, 2'd1, 3'b100, 2'd3, 32'h1, MEMW, 32'h0, 32'h0);
    chk("lbu_const", rf_wdata, 32'h00000080);
    cycle(1, 0, 0, 1, 5'd7, 2'd1, 3'b001, 2'd2, 32'h1, MEMW, 32'h0, 32'h0);
    chk("lh_const", rf_wdata, 32'hFFFF8070);
    cycle(1, 0, 0, 1, 5'd7, 2'd1, 3'b101, 2'd0, 32'h1, MEMW, 32'h0, 32'h0);
    chk("lhu_const", rf_wdata, 32'h0000F0A5);
    cycle(1, 0, 0, 1, 5'd7, 2'd1, 3'b011, 2'd0, 32'h1, MEMW, 32'h0, 32'h0);

    // Misaligned loads: pulse for one cycle only
    cycle(1, 0, 0, 1, 5'd7, 2'd1, 3'b010, 2'd1, 32'h1, MEMW, 32'h0, 32'h0);
    chk("lw_mis_pulse", ld_misalign, 1);
    idle();
    cycle(1, 0, 0, 1, 5'd7, 2'd1, 3'b001, 2'd3, 32'h1, MEMW, 32'h0, 32'h0);
    idle();

    // x0 write suppressed, JAL link value, CSR source
    cycle(1, 0, 0, 1, 5'd0, 2'd0, 3'd0, 2'd0, 32'h12345678, 32'h0, 32'h0, 32'h0);
    cycle(1, 0, 0, 1, 5'd1, 2'd2, 3'd0, 2'd0, 32'h0, 32'h0, 32'h104, 32'h0);
    chk("jal_wdata_const", rf_wdata, 32'h104);
    cycle(1, 0, 0, 1, 5'd31, 2'd3, 3'd0, 2'd0, 32'h0, 32'h0, 32'h0, 32'hC0FFEE00);

    // Stall held three cycles, then flush, then release
    repeat (3) cycle(1, 1, 0, 1, 5'd9, 2'd0, 3'd0, 2'd0, 32'hAAAA5555, 32'h0, 32'h0, 32'h0);
    cycle(1, 0, 1, 1, 5'd9, 2'd0, 3'd0, 2'd0, 32'hAAAA5555, 32'h0, 32'h0, 32'h0);
    cycle(1, 0, 0, 1, 5'd9, 2'd0, 3'd0, 2'd0, 32'hAAAA5555, 32'h0, 32'h0, 32'h0);
    idle();

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0,
            1'($urandom), 5'($urandom), 2'($urandom), 3'($urandom), 2'($urandom),
            $urandom, $urandom, $urandom, $urandom);
    end

    // Reset mid-stream: registered write and offered instruction both discarded
    cycle(1, 0, 0, 1, 5'd12, 2'd0, 3'd0, 2'd0, 32'h5A5A5A5A, 32'h0, 32'h0, 32'h0);
    in_valid = 1; in_reg_we = 1; in_rd = 5'd13; in_alu_data = 32'h77777777;
    rst_n = 1'b0;
    #1;
    chk_all_zero("midreset");
    @(negedge clk);
    chk_all_zero("midreset_hold");
    rst_n = 1'b1;
`ifdef WB_RETIRE_CNT_EN
    exp_cnt = '0;
`endif
    idle();

`ifdef WB_RETIRE_CNT_EN
    // Ten accepted instructions, two targeting x0
    for (int i = 0; i < 10; i++) begin
      cycle(1, 0, 0, 1, (i % 5 == 0) ? 5'd0 : 5'(i), 2'd0, 3'd0, 2'd0, $urandom, 32'h0, 32'h0, 32'h0);
    end
    idle();
    chk("retire_10", retire_count, 10);
    for (int i = 0; i < 6; i++) begin
      cycle(1, 0, 0, 0, 5'd3, 2'd0, 3'd0, 2'd0, 32'h0, 32'h0, 32'h0, 32'h0);
    end
    idle();
    chk("retire_wrap", retire_count, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
